ac97_sample_router: RTL and testbench

Parametrised sample router between the AC'97 datapath's parallel stereo ports and user DSP logic. It replaces the fixed hard-wired loopback and single black-box algorithm with run-time modes: loopback, buffered streaming, mute and test tone. Streaming uses valid/ready handshakes and per-direction FIFOs, with configurable sample width and depth. It sits between the `ac97` datapath instance and any Sysgen-generated algorithm in the top-level audio controller.

---
 rtl/ac97_sample_router.sv | 220 ++++++++++++++++++++++
 tb/tb_ac97_sample_router.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_sample_router.sv
// Run-time sample router between the AC'97 datapath stereo ports and user DSP logic.
// Modes: loopback, FIFO-buffered valid/ready streaming, mute and square-wave test tone.
module ac97_sample_router #(
   parameter int SAMPLE_W   = 18,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 8,
   parameter int TONE_HALF  = 24
) (
   input  logic                          clk,
   input  logic                          n_reset,
   input  logic [1:0]                    mode,
   input  logic                          frame_strobe,
   input  logic [SAMPLE_W-1:0]           codec_l_in,
   input  logic [SAMPLE_W-1:0]           codec_r_in,
   output logic [SAMPLE_W-1:0]           codec_l_out,
   output logic [SAMPLE_W-1:0]           codec_r_out,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [DATA_W-1:0]             rx_left,
   output logic [DATA_W-1:0]             rx_right,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [DATA_W-1:0]             tx_left,
   input  logic [DATA_W-1:0]             tx_right,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic                          overrun,
   output logic                          underrun,
   input  logic                          clr_status
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int CW    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam int SHIFT = DATA_W - SAMPLE_W;
   localparam logic [SAMPLE_W-1:0] TONE_POS = SAMPLE_W'(1) << (SAMPLE_W - 2);
   localparam logic [SAMPLE_W-1:0] TONE_NEG = -TONE_POS;
   localparam logic [LW-1:0]       FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0]       CNT_LAST = CW'(TONE_HALF - 1);

   typedef enum logic [1:0] {
      MODE_LOOP   = 2'd0,
      MODE_STREAM = 2'd1,
      MODE_MUTE   = 2'd2,
      MODE_TONE   = 2'd3
   } mode_e;

   logic                  strobe_q, evt_q;
   logic                  evt_d;
   mode_e                 mode_q, mode_d, modeEff;
   logic [CW-1:0]         cnt_q, cnt_d, cntCur;
   logic                  phase_q, phase_d, phaseCur;
   logic [SAMPLE_W-1:0]   outL_q, outL_d, outR_q, outR_d;
   logic                  overrun_q, overrun_d, underrun_q, underrun_d;
   logic [AW-1:0]         rxRd_q, rxRd_d, rxWr_q, rxWr_d;
   logic [AW-1:0]         txRd_q, txRd_d, txWr_q, txWr_d;
   logic [LW-1:0]         rxCnt_q, rxCnt_d, txCnt_q, txCnt_d;
   logic [2*DATA_W-1:0]   rxMem_q [FIFO_DEPTH];
   logic [2*SAMPLE_W-1:0] txMem_q [FIFO_DEPTH];
   logic [2*DATA_W-1:0]   rxHead;
   logic [2*SAMPLE_W-1:0] txHead;
   logic [DATA_W-1:0]     wideL, wideR;
   logic                  streamEvt, flush;
   logic                  rxEmpty, rxFull, txEmpty, txFull;
   logic                  rxPop, rxPush, txPop, txPush, overSet, underSet;
   logic                  unusedTxLowBits;

   // Only the top SAMPLE_W bits of each TX word ever reach the codec.
   assign unusedTxLowBits = ^{tx_left, tx_right};

   assign rxEmpty  = (rxCnt_q == '0);
   assign rxFull   = (rxCnt_q == FULL_LVL);
   assign txEmpty  = (txCnt_q == '0);
   assign txFull   = (txCnt_q == FULL_LVL);
   assign rx_valid = (mode_q == MODE_STREAM) & ~rxEmpty;
   assign tx_ready = (mode_q == MODE_STREAM) & ~txFull;
   assign rxHead   = rxMem_q[rxRd_q];
   assign txHead   = txMem_q[txRd_q];
   assign rx_left  = rx_valid ? rxHead[2*DATA_W-1 -: DATA_W] : '0;
   assign rx_right = rx_valid ? rxHead[DATA_W-1:0] : '0;
   assign rx_level = rxCnt_q;
   assign tx_level = txCnt_q;
   assign codec_l_out = outL_q;
   assign codec_r_out = outR_q;
   assign overrun  = overrun_q;
   assign underrun = underrun_q;
   assign wideL    = DATA_W'(codec_l_in) << SHIFT;
   assign wideR    = DATA_W'(codec_r_in) << SHIFT;

   // The mode presented at an event already governs that event.
   always_comb begin
      modeEff   = evt_q ? mode_e'(mode) : mode_q;
      streamEvt = evt_q & (modeEff == MODE_STREAM);
      flush     = (modeEff != MODE_STREAM);
      rxPop     = rx_valid & rx_ready;
      rxPush    = streamEvt & (~rxFull | rxPop);
      overSet   = streamEvt & rxFull & ~rxPop;
      txPush    = tx_valid & tx_ready;
      txPop     = streamEvt & ~txEmpty;
      underSet  = streamEvt & txEmpty;
      cntCur    = (mode_q != MODE_TONE) ? '0 : cnt_q;
      phaseCur  = (mode_q != MODE_TONE) ? 1'b0 : phase_q;
   end

   always_comb begin
      evt_d      = frame_strobe & ~strobe_q;
      mode_d     = modeEff;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      outL_d     = outL_q;
      outR_d     = outR_q;
      overrun_d  = overrun_q;
      underrun_d = underrun_q;
      rxRd_d     = rxRd_q;
      rxWr_d     = rxWr_q;
      rxCnt_d    = rxCnt_q;
      txRd_d     = txRd_q;
      txWr_d     = txWr_q;
      txCnt_d    = txCnt_q;

      if (evt_q) begin
         case (modeEff)
            MODE_LOOP: begin
               outL_d = codec_l_in;
               outR_d = codec_r_in;
            end
            MODE_MUTE: begin
               outL_d = '0;
               outR_d = '0;
            end
            MODE_TONE: begin
               outL_d = phaseCur ? TONE_NEG : TONE_POS;
               outR_d = phaseCur ? TONE_NEG : TONE_POS;
               if (cntCur == CNT_LAST) begin
                  cnt_d   = '0;
                  phase_d = ~phaseCur;
               end else begin
                  cnt_d   = cntCur + 1'b1;
                  phase_d = phaseCur;
               end
            end
            default: begin
               outL_d = txEmpty ? '0 : txHead[2*SAMPLE_W-1 -: SAMPLE_W];
               outR_d = txEmpty ? '0 : txHead[SAMPLE_W-1:0];
            end
         endcase
      end

      if (flush) begin
         rxRd_d  = '0;
         rxWr_d  = '0;
         rxCnt_d = '0;
         txRd_d  = '0;
         txWr_d  = '0;
         txCnt_d = '0;
      end else begin
         rxRd_d  = rxRd_q + AW'(rxPop);
         rxWr_d  = rxWr_q + AW'(rxPush);
         rxCnt_d = rxCnt_q + LW'(rxPush) - LW'(rxPop);
         txRd_d  = txRd_q + AW'(txPop);
         txWr_d  = txWr_q + AW'(txPush);
         txCnt_d = txCnt_q + LW'(txPush) - LW'(txPop);
      end

      // A new error wins over a clear arriving in the same cycle.
      if ((mode_q == MODE_STREAM) && clr_status) begin
         overrun_d  = 1'b0;
         underrun_d = 1'b0;
      end
      if (overSet)
         overrun_d = 1'b1;
      if (underSet)
         underrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         strobe_q   <= 1'b0;
         evt_q      <= 1'b0;
         mode_q     <= MODE_LOOP;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         outL_q     <= '0;
         outR_q     <= '0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         rxRd_q     <= '0;
         rxWr_q     <= '0;
         rxCnt_q    <= '0;
         txRd_q     <= '0;
         txWr_q     <= '0;
         txCnt_q    <= '0;
      end else begin
         strobe_q   <= frame_strobe;
         evt_q      <= evt_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         outL_q     <= outL_d;
         outR_q     <= outR_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
         rxRd_q     <= rxRd_d;
         rxWr_q     <= rxWr_d;
         rxCnt_q    <= rxCnt_d;
         txRd_q     <= txRd_d;
         txWr_q     <= txWr_d;
         txCnt_q    <= txCnt_d;
      end
   end

   // Sample storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (rxPush)
         rxMem_q[rxWr_q] <= {wideL, wideR};
      if (txPush)
         txMem_q[txWr_q] <= {tx_left[DATA_W-1 -: SAMPLE_W], tx_right[DATA_W-1 -: SAMPLE_W]};
   end

endmodule

// File: tb/tb_ac97_sample_router.sv
// Self-checking bench for ac97_sample_router: directed vectors and sequences, then
// randomized traffic compared against a queue-based reference model.
module tb_ac97_sample_router;

   localparam int SW    = 18;
   localparam int DW    = 24;
   localparam int DEPTH = 8;
   localparam int TH    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam logic [SW-1:0] APOS = 18'h10000;
   localparam logic [SW-1:0] ANEG = 18'h30000;

   logic          clk = 1'b0;
   logic          n_reset;
   logic [1:0]    mode;
   logic          frame_strobe;
   logic [SW-1:0] codec_l_in, codec_r_in, codec_l_out, codec_r_out;
   logic          rx_valid, rx_ready, tx_valid, tx_ready;
   logic [DW-1:0] rx_left, rx_right, tx_left, tx_right;
   logic [LW-1:0] rx_level, tx_level;
   logic          overrun, underrun, clr_status;

   int testsRun = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]    m;
      logic [SW-1:0] l;
      logic [SW-1:0] r;
      logic [SW-1:0] expL;
      logic [SW-1:0] expR;
   } vec_t;
   vec_t vecs[8];

   // reference model state
   logic [47:0]   rxQ[$];
   logic [35:0]   txQ[$];
   logic [1:0]    mMode;
   bit            mEvt, mStrobe, mOvr, mUnd;
   logic [SW-1:0] mOutL, mOutR;
   int            toneIdx;

   ac97_sample_router #(.SAMPLE_W(SW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TONE_HALF(TH)) dut (
      .clk(clk), .n_reset(n_reset), .mode(mode), .frame_strobe(frame_strobe),
      .codec_l_in(codec_l_in), .codec_r_in(codec_r_in),
      .codec_l_out(codec_l_out), .codec_r_out(codec_r_out),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_left(rx_left), .rx_right(rx_right),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_left(tx_left), .tx_right(tx_right),
      .rx_level(rx_level), .tx_level(tx_level),
      .overrun(overrun), .underrun(underrun), .clr_status(clr_status));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
      testsRun++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [SW-1:0] l, input logic [SW-1:0] r);
      mode       = m;
      codec_l_in = l;
      codec_r_in = r;
   endtask

   task automatic frameEvent();
      frame_strobe = 1'b1;
      tick();
      frame_strobe = 1'b0;
      tick();
   endtask

   function automatic logic [DW-1:0] widen(input logic [SW-1:0] s);
      return DW'(s * (1 << (DW - SW)));
   endfunction

   function automatic logic [SW-1:0] trunc(input logic [DW-1:0] d);
      return SW'(d / (1 << (DW - SW)));
   endfunction

   task automatic modelReset();
      rxQ.delete();
      txQ.delete();
      mMode = 2'd0; mEvt = 0; mStrobe = 0; mOvr = 0; mUnd = 0;
      mOutL = '0; mOutR = '0; toneIdx = 0;
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic modelStep();
      logic [1:0]  eff;
      logic [35:0] head;
      bit          rxPop, txPush, ovrSet, undSet;
      ovrSet = 0;
      undSet = 0;
      eff    = mEvt ? mode : mMode;
      rxPop  = (mMode == 2'd1) && (rxQ.size() > 0) && rx_ready;
      txPush = (mMode == 2'd1) && (txQ.size() < DEPTH) && tx_valid;
      if (eff != 2'd1) begin
         rxQ.delete();
         txQ.delete();
      end else begin
         if (rxPop) void'(rxQ.pop_front());
         if (mEvt) begin
            if (rxQ.size() < DEPTH) rxQ.push_back({widen(codec_l_in), widen(codec_r_in)});
            else ovrSet = 1;
            if (txQ.size() > 0) begin
               head  = txQ.pop_front();
               mOutL = head[35:18];
               mOutR = head[17:0];
            end else begin
               mOutL = '0;
               mOutR = '0;
               undSet = 1;
            end
         end
         if (txPush) txQ.push_back({trunc(tx_left), trunc(tx_right)});
      end
      if (mEvt) begin
         if (eff == 2'd0) begin
            mOutL = codec_l_in;
            mOutR = codec_r_in;
         end else if (eff == 2'd2) begin
            mOutL = '0;
            mOutR = '0;
         end else if (eff == 2'd3) begin
            if (mMode != 2'd3) toneIdx = 0;
            mOutL = ((toneIdx / TH) % 2 == 1) ? ANEG : APOS;
            mOutR = mOutL;
            toneIdx++;
         end
      end
      if (mMode == 2'd1 && clr_status) begin
         mOvr = 0;
         mUnd = 0;
      end
      if (ovrSet) mOvr = 1;
      if (undSet) mUnd = 1;
      mMode   = eff;
      mEvt    = frame_strobe && !mStrobe;
      mStrobe = frame_strobe;
   endtask

   task automatic checkAgainstModel();
      bit expValid;
      expValid = (mMode == 2'd1) && (rxQ.size() > 0);
      checkOutput("rnd codec_l_out", codec_l_out, mOutL);
      checkOutput("rnd codec_r_out", codec_r_out, mOutR);
      checkOutput("rnd rx_valid", rx_valid, expValid);
      checkOutput("rnd tx_ready", tx_ready, (mMode == 2'd1) && (txQ.size() < DEPTH));
      checkOutput("rnd rx_level", rx_level, rxQ.size());
      checkOutput("rnd tx_level", tx_level, txQ.size());
      checkOutput("rnd overrun", overrun, mOvr);
      checkOutput("rnd underrun", underrun, mUnd);
      if (expValid) begin
         checkOutput("rnd rx_left", rx_left, rxQ[0][47:24]);
         checkOutput("rnd rx_right", rx_right, rxQ[0][23:0]);
      end
   endtask

   initial begin
      logic [SW-1:0] prevL, prevR;
      logic [DW-1:0] drainExp[8];
      int            r;

      vecs[0] = '{2'd0, 18'h12345, 18'h3FFFF, 18'h12345, 18'h3FFFF};
      vecs[1] = '{2'd2, 18'h00777, 18'h00777, 18'h00000, 18'h00000};
      vecs[2] = '{2'd0, 18'h20000, 18'h00001, 18'h20000, 18'h00001};
      vecs[3] = '{2'd3, 18'h11111, 18'h22222, APOS, APOS};
      vecs[4] = '{2'd3, 18'h11111, 18'h22222, APOS, APOS};
      vecs[5] = '{2'd0, 18'h2AAAA, 18'h15555, 18'h2AAAA, 18'h15555};
      vecs[6] = '{2'd3, 18'h00000, 18'h00000, APOS, APOS};
      vecs[7] = '{2'd2, 18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h00000};

      n_reset = 1'b0; frame_strobe = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
      tx_left = '0; tx_right = '0; clr_status = 1'b0;
      applyStimulus(2'd0, '0, '0);
      #22;
      checkOutput("reset codec_l_out", codec_l_out, 0);
      checkOutput("reset codec_r_out", codec_r_out, 0);
      checkOutput("reset rx_valid", rx_valid, 0);
      checkOutput("reset rx_left", rx_left, 0);
      checkOutput("reset tx_ready", tx_ready, 0);
      checkOutput("reset levels", {rx_level, tx_level}, 0);
      checkOutput("reset flags", {overrun, underrun}, 0);
      @(negedge clk);
      n_reset = 1'b1;
      tick();

      // table: output holds one cycle after the strobe, updates on the next
      prevL = '0; prevR = '0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].m, vecs[i].l, vecs[i].r);
         frame_strobe = 1'b1;
         tick();
         checkOutput($sformatf("vec%0d hold l", i), codec_l_out, prevL);
         frame_strobe = 1'b0;
         tick();
         checkOutput($sformatf("vec%0d l", i), codec_l_out, vecs[i].expL);
         checkOutput($sformatf("vec%0d r", i), codec_r_out, vecs[i].expR);
         prevL = vecs[i].expL;
         prevR = vecs[i].expR;
      end

      // held-high strobe gives a single event
      applyStimulus(2'd0, 18'h00AAA, 18'h00AAB);
      frame_strobe = 1'b1;
      tick(); tick();
      codec_l_in = 18'h00BBB;
      tick(); tick();
      checkOutput("held strobe single event", codec_l_out, 18'h00AAA);
      frame_strobe = 1'b0;
      tick();

      // RX widening, overflow, clear, full-boundary simultaneity and drain order
      applyStimulus(2'd1, 18'h20001, 18'h00005);
      frameEvent();
      checkOutput("rx_valid after push", rx_valid, 1);
      checkOutput("rx_left widened", rx_left, 24'h800040);
      checkOutput("rx_right widened", rx_right, 24'h000140);
      checkOutput("rx_level one", rx_level, 1);
      for (int k = 1; k <= 8; k++) begin
         codec_l_in = SW'(k);
         frameEvent();
      end
      checkOutput("overrun after depth+1", overrun, 1);
      checkOutput("rx_level full", rx_level, 8);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      checkOutput("overrun cleared", overrun, 0);
      checkOutput("underrun cleared", underrun, 0);
      codec_l_in = 18'h00012;
      frame_strobe = 1'b1;
      tick();
      rx_ready = 1'b1;
      frame_strobe = 1'b0;
      tick();
      rx_ready = 1'b0;
      checkOutput("full+pop no overrun", overrun, 0);
      checkOutput("full+pop level", rx_level, 8);
      for (int k = 0; k < 7; k++) drainExp[k] = DW'((k + 1) * 64);
      drainExp[7] = 24'h000480;
      rx_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("drain%0d rx_left", k), rx_left, drainExp[k]);
         tick();
      end
      rx_ready = 1'b0;
      checkOutput("drained rx_valid", rx_valid, 0);
      checkOutput("drained rx_level", rx_level, 0);

      // TX truncation then underrun
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      checkOutput("underrun clear before tx", underrun, 0);
      tx_left = 24'hABCDEF; tx_right = 24'h123456; tx_valid = 1'b1;
      checkOutput("tx_ready stream", tx_ready, 1);
      tick();
      tx_valid = 1'b0;
      checkOutput("tx_level one", tx_level, 1);
      frameEvent();
      checkOutput("tx trunc l", codec_l_out, 18'h2AF37);
      checkOutput("tx trunc r", codec_r_out, 18'h048D1);
      checkOutput("no underrun", underrun, 0);
      frameEvent();
      checkOutput("underrun out l", codec_l_out, 0);
      checkOutput("underrun set", underrun, 1);

      // flush on leaving stream
      tx_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tx_left = DW'(24'h100000 * (k + 1));
         tick();
      end
      tx_valid = 1'b0;
      checkOutput("tx_level three", tx_level, 3);
      applyStimulus(2'd2, 18'h1, 18'h1);
      frameEvent();
      checkOutput("flush tx_level", tx_level, 0);
      checkOutput("flush rx_level", rx_level, 0);
      checkOutput("flush tx_ready", tx_ready, 0);
      checkOutput("mute outputs", {codec_l_out, codec_r_out}, 0);

      // tone pattern
      applyStimulus(2'd3, 18'h0, 18'h0);
      for (int k = 0; k < 12; k++) begin
         frameEvent();
         checkOutput($sformatf("tone%0d l", k), codec_l_out, ((k / TH) % 2 == 1) ? ANEG : APOS);
         checkOutput($sformatf("tone%0d r", k), codec_r_out, ((k / TH) % 2 == 1) ? ANEG : APOS);
      end

      // asynchronous reset between edges
      #2;
      n_reset = 1'b0;
      #1;
      checkOutput("async reset l", codec_l_out, 0);
      checkOutput("async reset r", codec_r_out, 0);
      checkOutput("async reset rx_level", rx_level, 0);
      tick(); tick();
      applyStimulus(2'd1, '0, '0);
      @(negedge clk);
      n_reset = 1'b1;
      tick();

      // randomized traffic against the reference model
      modelReset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 24) == 0) begin
            r = $urandom_range(0, 5);
            case (r)
               3: mode = 2'd0;
               4: mode = 2'd2;
               5: mode = 2'd3;
               default: mode = 2'd1;
            endcase
         end
         frame_strobe = ($urandom_range(0, 2) == 0);
         codec_l_in   = SW'($urandom);
         codec_r_in   = SW'($urandom);
         rx_ready     = ($urandom_range(0, 3) == 0);
         tx_valid     = ($urandom_range(0, 2) == 0);
         tx_left      = DW'($urandom);
         tx_right     = DW'($urandom);
         clr_status   = ($urandom_range(0, 39) == 0);
         modelStep();
         tick();
         checkAgainstModel();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
